// File: rtl/RS5_pkg.sv
// -----------------------------------------------------------------------------
// RS5_pkg
// Shared constants and types for the plugin pixel DMA.
//   - Plugin register map (RGB input, auxiliary, gray output, control/status)
//   - Plugin status bit positions and the start command word
//   - FSM state enumeration used by plugin_pixel_dma
// -----------------------------------------------------------------------------
package RS5_pkg;

    // Plugin register map
    localparam logic [31:0] PL_RGB_ADDR  = 32'h1000_0000;
    localparam logic [31:0] PL_AUX_ADDR  = 32'h1000_0004;
    localparam logic [31:0] PL_GRAY_ADDR = 32'h1000_0008;
    localparam logic [31:0] PL_CSR_ADDR  = 32'h1000_000C;

    // Plugin status word bit positions (read from PL_CSR_ADDR)
    localparam int PL_STAT_BUSY_BIT = 0;
    localparam int PL_STAT_DONE_BIT = 1;

    // Command word that kicks off one conversion
    localparam logic [31:0] PL_CMD_START = 32'h0000_0001;

    // Address step between consecutive pixels (one 32-bit word)
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        MEM_RD     = 4'd1,
        MEM_CAP    = 4'd2,
        PL_WR_RGB  = 4'd3,
        PL_START   = 4'd4,
        PL_POLL    = 4'd5,
        PL_RD_GRAY = 4'd6,
        MEM_WR     = 4'd7,
        FINISH     = 4'd8
    } dma_state_t;

    // Only the done bit ends polling; the busy bit carries no information
    // the DMA needs.
    function automatic logic pl_status_done(input logic [31:0] status);
        return status[PL_STAT_DONE_BIT];
    endfunction

endpackage

// File: rtl/plugin_pixel_dma.sv
// -----------------------------------------------------------------------------
// plugin_pixel_dma
// Streams RGB pixels from data memory through a register-mapped gray-scale
// plugin and writes the results back to memory, one pixel at a time.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start_i                     one-cycle job start (ignored while busy)
//   src_addr_i, dst_addr_i      word-aligned source / destination base
//   count_i                     number of pixels in the job
//   busy_o, done_o, error_o     job active, completion pulse, sticky timeout
//   processed_o                 pixels written back in current/last job
//   mem_*                       data-memory initiator (read data 1 cycle later)
//   pl_*                        plugin register port (read data same cycle)
//
// All bus outputs are registered: they are decoded from the next state so
// they line up exactly with the state that owns them.
// -----------------------------------------------------------------------------
import RS5_pkg::*;

module plugin_pixel_dma #(
    parameter int POLL_LIMIT = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] processed_o,
    output logic             mem_enable_o,
    output logic [3:0]       mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic [31:0]      mem_data_i,
    output logic             pl_enable_o,
    output logic [3:0]       pl_we_o,
    output logic [31:0]      pl_addr_o,
    output logic [31:0]      pl_data_o,
    input  logic [31:0]      pl_data_i
);

    localparam int          POLL_W       = $clog2(POLL_LIMIT + 1);
    localparam logic [31:0] POLL_LIMIT_W = 32'(POLL_LIMIT);

    dma_state_t       state_reg, state_next;
    logic [31:0]      src_reg, src_next;
    logic [31:0]      dst_reg, dst_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] processed_reg, processed_next;
    logic [31:0]      pixel_reg, pixel_next;
    logic [31:0]      result_reg, result_next;
    logic [POLL_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic             error_reg, error_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;

    logic             mem_en_reg, mem_en_next;
    logic [3:0]       mem_we_reg, mem_we_next;
    logic [31:0]      mem_addr_reg, mem_addr_next;
    logic [31:0]      mem_data_reg, mem_data_next;
    logic             pl_en_reg, pl_en_next;
    logic [3:0]       pl_we_reg, pl_we_next;
    logic [31:0]      pl_addr_reg, pl_addr_next;
    logic [31:0]      pl_data_reg, pl_data_next;

    logic [31:0]      polls_done;   // polls completed including the current one

    assign polls_done = 32'(poll_cnt_reg) + 32'd1;

    // Next-state and datapath
    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        count_next     = count_reg;
        processed_next = processed_reg;
        pixel_next     = pixel_reg;
        result_next    = result_reg;
        poll_cnt_next  = poll_cnt_reg;
        error_next     = error_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    src_next       = src_addr_i;
                    dst_next       = dst_addr_i;
                    count_next     = count_i;
                    processed_next = '0;
                    error_next     = 1'b0;
                    state_next     = (count_i != '0) ? MEM_RD : FINISH;
                end
            end
            MEM_RD:    state_next = MEM_CAP;
            MEM_CAP: begin
                pixel_next = mem_data_i;
                state_next = PL_WR_RGB;
            end
            PL_WR_RGB: state_next = PL_START;
            PL_START: begin
                poll_cnt_next = '0;
                state_next    = PL_POLL;
            end
            PL_POLL: begin
                if (pl_status_done(pl_data_i)) begin
                    state_next = PL_RD_GRAY;
                end else if (polls_done >= POLL_LIMIT_W) begin
                    // Plugin never finished: abandon the rest of the job.
                    error_next = 1'b1;
                    state_next = FINISH;
                end else begin
                    poll_cnt_next = poll_cnt_reg + POLL_W'(1);
                end
            end
            PL_RD_GRAY: begin
                result_next = pl_data_i;
                state_next  = MEM_WR;
            end
            MEM_WR: begin
                processed_next = processed_reg + CNT_W'(1);
                src_next       = src_reg + WORD_STRIDE;
                dst_next       = dst_reg + WORD_STRIDE;
                state_next     = (processed_next == count_reg) ? FINISH : MEM_RD;
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode from the state being entered, so bus signals are
    // registered and valid for the whole cycle spent in that state.
    always_comb begin
        mem_en_next   = 1'b0;
        mem_we_next   = 4'h0;
        mem_addr_next = 32'h0;
        mem_data_next = 32'h0;
        pl_en_next    = 1'b0;
        pl_we_next    = 4'h0;
        pl_addr_next  = 32'h0;
        pl_data_next  = 32'h0;
        busy_next     = (state_next != IDLE);
        // done lands in the cycle after FINISH, when the FSM is back in IDLE
        done_next     = (state_reg == FINISH);

        case (state_next)
            MEM_RD: begin
                mem_en_next   = 1'b1;
                mem_addr_next = src_next;
            end
            MEM_WR: begin
                mem_en_next   = 1'b1;
                mem_we_next   = 4'hF;
                mem_addr_next = dst_next;
                mem_data_next = result_next;
            end
            PL_WR_RGB: begin
                pl_en_next   = 1'b1;
                pl_we_next   = 4'hF;
                pl_addr_next = PL_RGB_ADDR;
                pl_data_next = pixel_next;
            end
            PL_START: begin
                pl_en_next   = 1'b1;
                pl_we_next   = 4'hF;
                pl_addr_next = PL_CSR_ADDR;
                pl_data_next = PL_CMD_START;
            end
            PL_POLL: begin
                pl_en_next   = 1'b1;
                pl_addr_next = PL_CSR_ADDR;
            end
            PL_RD_GRAY: begin
                pl_en_next   = 1'b1;
                pl_addr_next = PL_GRAY_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            src_reg       <= 32'h0;
            dst_reg       <= 32'h0;
            count_reg     <= '0;
            processed_reg <= '0;
            pixel_reg     <= 32'h0;
            result_reg    <= 32'h0;
            poll_cnt_reg  <= '0;
            error_reg     <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 4'h0;
            mem_addr_reg  <= 32'h0;
            mem_data_reg  <= 32'h0;
            pl_en_reg     <= 1'b0;
            pl_we_reg     <= 4'h0;
            pl_addr_reg   <= 32'h0;
            pl_data_reg   <= 32'h0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            count_reg     <= count_next;
            processed_reg <= processed_next;
            pixel_reg     <= pixel_next;
            result_reg    <= result_next;
            poll_cnt_reg  <= poll_cnt_next;
            error_reg     <= error_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_data_reg  <= mem_data_next;
            pl_en_reg     <= pl_en_next;
            pl_we_reg     <= pl_we_next;
            pl_addr_reg   <= pl_addr_next;
            pl_data_reg   <= pl_data_next;
        end
    end

    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign error_o      = error_reg;
    assign processed_o  = processed_reg;
    assign mem_enable_o = mem_en_reg;
    assign mem_we_o     = mem_we_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;
    assign pl_enable_o  = pl_en_reg;
    assign pl_we_o      = pl_we_reg;
    assign pl_addr_o    = pl_addr_reg;
    assign pl_data_o    = pl_data_reg;

endmodule
